// File: rtl/score_keeper.sv
// ============================================================================
//  Module      : score_keeper
//  Description : Debounced basketball score counter producing a packed
//                two-team BCD score bus for the 7-segment display scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_keeper #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int CNT_W      = 20
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [3:0]  key_a,
    input  logic [3:0]  key_b,
    input  logic        key_clr,
    output logic [15:0] score,
    output logic        score_vld
);

    localparam int              N_KEYS  = 9;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    // Bit order: [3:0] team A, [7:4] team B, [8] clear
    logic [N_KEYS-1:0] raw;
    assign raw = {key_clr, key_b, key_a};

    logic [N_KEYS-1:0] sync1_q, sync2_q;
    logic [N_KEYS-1:0] deb_q, deb_d;
    logic [N_KEYS-1:0] deb_dly_q;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [CNT_W-1:0]  cnt_q [N_KEYS];
    logic [CNT_W-1:0]  cnt_d [N_KEYS];
    logic [15:0]       score_q, score_d;
    logic              score_vld_q, score_vld_d;

    // Two-digit BCD step; increments win over the decrement, clear wins over all
    function automatic logic [7:0] bcd_next(input logic [7:0] cur,
                                            input logic [3:0] op,
                                            input logic       clr);
        logic [3:0] ones;
        logic [3:0] tens;
        logic [3:0] inc;
        logic [7:0] res;
        ones = cur[3:0];
        tens = cur[7:4];
        res  = cur;
        inc  = 4'd0;
        if (op[2])      inc = 4'd3;
        else if (op[1]) inc = 4'd2;
        else if (op[0]) inc = 4'd1;

        if (clr) begin
            res = 8'h00;
        end else if (inc != 4'd0) begin
            ones = ones + inc;
            if (ones > 4'd9) begin
                ones = ones - 4'd10;
                tens = tens + 4'd1;
            end
            res = (tens > 4'd9) ? 8'h99 : {tens, ones};
        end else if (op[3] && (cur != 8'h00)) begin
            if (ones == 4'd0) begin
                ones = 4'd9;
                tens = tens - 4'd1;
            end else begin
                ones = ones - 4'd1;
            end
            res = {tens, ones};
        end
        return res;
    endfunction

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < N_KEYS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign press_d = deb_q & ~deb_dly_q;

    always_comb begin
        score_d     = {bcd_next(score_q[15:8], press_q[3:0], press_q[8]),
                       bcd_next(score_q[7:0],  press_q[7:4], press_q[8])};
        score_vld_d = (score_d != score_q);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_dly_q   <= '0;
            press_q     <= '0;
            score_q     <= '0;
            score_vld_q <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_dly_q   <= deb_q;
            press_q     <= press_d;
            score_q     <= score_d;
            score_vld_q <= score_vld_d;
            for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign score     = score_q;
    assign score_vld = score_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
//  Module      : tb_score_keeper
//  Description : Directed bench for score_keeper with an expected-score queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_keeper;

    localparam int DEB = 4;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b1;
    logic [3:0]  key_a  = 4'b0;
    logic [3:0]  key_b  = 4'b0;
    logic        key_clr = 1'b0;
    logic [15:0] score;
    logic        score_vld;

    int          n_cmp   = 0;
    int          n_err   = 0;
    int          vld_cnt = 0;
    int          ma      = 0;
    int          mb      = 0;
    int          v0;
    logic [15:0] exp_q [$];

    score_keeper #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .key_a    (key_a),
        .key_b    (key_b),
        .key_clr  (key_clr),
        .score    (score),
        .score_vld(score_vld)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int a, input int b);
        return {4'(a / 10), 4'(a % 10), 4'(b / 10), 4'(b % 10)};
    endfunction

    // Every score_vld pulse must deliver the next queued score
    always @(negedge clk_in) begin
        if (rst === 1'b0 && score_vld === 1'b1) begin
            vld_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected_vld observed=%h expected=none", score);
            end else begin
                check("sb_score", score, exp_q.pop_front());
            end
        end
    end

    task automatic press_keys(input logic [3:0] ka, input logic [3:0] kb, input logic kc);
        @(posedge clk_in); #1;
        key_a = ka; key_b = kb; key_clr = kc;
        repeat (8) @(posedge clk_in);
        #1;
        key_a = 4'b0; key_b = 4'b0; key_clr = 1'b0;
        repeat (10) @(posedge clk_in);
    endtask

    task automatic op(input int team, input int b);
        int old_v, new_v;
        old_v = (team == 0) ? ma : mb;
        case (b)
            0:       new_v = (old_v + 1 > 99) ? 99 : old_v + 1;
            1:       new_v = (old_v + 2 > 99) ? 99 : old_v + 2;
            2:       new_v = (old_v + 3 > 99) ? 99 : old_v + 3;
            default: new_v = (old_v > 0) ? old_v - 1 : 0;
        endcase
        if (team == 0) ma = new_v; else mb = new_v;
        if (new_v != old_v) exp_q.push_back(to_bcd(ma, mb));
        if (team == 0) press_keys(4'(1 << b), 4'b0, 1'b0);
        else           press_keys(4'b0, 4'(1 << b), 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk_in); #1;
        rst = 1'b1; key_a = 4'b0; key_b = 4'b0; key_clr = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        check("rst_score", score, 16'h0000);
        check("rst_vld", {15'b0, score_vld}, 16'd0);
        @(posedge clk_in); #1;
        rst = 1'b0;
        ma = 0; mb = 0; vld_cnt = 0;
        exp_q.delete();
    endtask

    initial begin
        // 1: exact latency of a single held +2 press
        do_reset();
        @(posedge clk_in); #1;
        key_a = 4'b0010;
        ma = 2;
        exp_q.push_back(16'h0200);
        repeat (DEB + 3) @(posedge clk_in);
        @(negedge clk_in);
        check("t1_before", score, 16'h0000);
        @(posedge clk_in);
        @(negedge clk_in);
        check("t1_score", score, 16'h0200);
        check("t1_vld", {15'b0, score_vld}, 16'd1);
        @(posedge clk_in);
        @(negedge clk_in);
        check("t1_vld_drop", {15'b0, score_vld}, 16'd0);
        repeat (10) @(posedge clk_in);
        #1 key_a = 4'b0;
        repeat (12) @(posedge clk_in);
        @(negedge clk_in);
        check("t1_held", score, 16'h0200);
        check("t1_pulses", 16'(vld_cnt), 16'd1);

        // 2: glitch train rejected, clean press accepted
        do_reset();
        @(posedge clk_in); #1;
        for (int i = 0; i < 4; i++) begin
            key_b[0] = 1'b1;
            repeat (3) @(posedge clk_in);
            #1 key_b[0] = 1'b0;
            @(posedge clk_in); #1;
        end
        repeat (10) @(posedge clk_in);
        @(negedge clk_in);
        check("t2_glitch", score, 16'h0000);
        mb = 1;
        exp_q.push_back(16'h0001);
        press_keys(4'b0, 4'b0001, 1'b0);
        @(negedge clk_in);
        check("t2_clean", score, 16'h0001);
        check("t2_pulses", 16'(vld_cnt), 16'd1);

        // 3: carries, borrows, saturation and floor
        do_reset();
        repeat (3) op(0, 2);
        check("t3_09", score, 16'h0900);
        op(0, 0);
        check("t3_10", score, 16'h1000);
        op(0, 3);
        check("t3_09b", score, 16'h0900);
        repeat (29) op(0, 2);
        op(0, 1);
        check("t3_98", score, 16'h9800);
        op(0, 2);
        check("t3_99", score, 16'h9900);
        v0 = vld_cnt;
        op(0, 0);
        check("t3_sat", score, 16'h9900);
        check("t3_sat_vld", 16'(vld_cnt - v0), 16'd0);
        do_reset();
        op(0, 3);
        check("t3_floor", score, 16'h0000);
        check("t3_floor_vld", 16'(vld_cnt), 16'd0);

        // 4: simultaneous presses, priority per team
        do_reset();
        op(0, 2); op(0, 1);
        op(1, 2); op(1, 2); op(1, 0);
        check("t4_pre", score, 16'h0507);
        ma = 8; mb = 6;
        exp_q.push_back(16'h0806);
        v0 = vld_cnt;
        press_keys(4'b0101, 4'b1000, 1'b0);
        check("t4_score", score, 16'h0806);
        check("t4_pulses", 16'(vld_cnt - v0), 16'd1);

        // 5: clear beats +3; clear at zero is silent
        do_reset();
        repeat (15) op(0, 2);
        repeat (12) op(1, 2);
        op(1, 0);
        check("t5_pre", score, 16'h4537);
        ma = 0; mb = 0;
        exp_q.push_back(16'h0000);
        v0 = vld_cnt;
        press_keys(4'b0100, 4'b0, 1'b1);
        check("t5_clr", score, 16'h0000);
        check("t5_clr_vld", 16'(vld_cnt - v0), 16'd1);
        v0 = vld_cnt;
        press_keys(4'b0, 4'b0, 1'b1);
        check("t5_clr0", score, 16'h0000);
        check("t5_clr0_vld", 16'(vld_cnt - v0), 16'd0);

        // 6: reset mid-debounce with key held throughout
        do_reset();
        @(posedge clk_in); #1;
        key_a = 4'b0001;
        repeat (4) @(posedge clk_in);
        #1 rst = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        check("t6_rst_score", score, 16'h0000);
        check("t6_rst_vld", {15'b0, score_vld}, 16'd0);
        @(posedge clk_in); #1;
        rst = 1'b0;
        vld_cnt = 0;
        exp_q.delete();
        ma = 1; mb = 0;
        exp_q.push_back(16'h0100);
        repeat (DEB + 3) @(posedge clk_in);
        @(negedge clk_in);
        check("t6_before", score, 16'h0000);
        @(posedge clk_in);
        @(negedge clk_in);
        check("t6_score", score, 16'h0100);
        check("t6_vld", {15'b0, score_vld}, 16'd1);
        #1 key_a = 4'b0;
        repeat (12) @(posedge clk_in);
        @(negedge clk_in);
        check("t6_pulses", 16'(vld_cnt), 16'd1);

        check("sb_drain", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
